// File: rtl/lock_code_sender_if.sv
// rtl/lock_code_sender_if.sv - signal bundle between controller, code sender and lock
//
// Purpose : groups the request, serial-link, response and status signals of
//           lock_code_sender so they travel as one port.
// Signals : start, code[CODE_W]        request from the controller
//           openlock, alarm            responses from the lock
//           out, valid                 serial code bit toward the lock input
//           busy, granted, denied      status back to the controller
//           tries[$clog2(MAX_TRIES+1)] attempts started for the current request
// Modports: slave  - the code sender itself
//           master - the surrounding controller/lock environment
interface lock_code_sender_if #(
    parameter int CODE_W    = 8,
    parameter int MAX_TRIES = 3
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    logic                start;
    logic [CODE_W-1:0]   code;
    logic                openlock;
    logic                alarm;
    logic                out;
    logic                valid;
    logic                busy;
    logic                granted;
    logic                denied;
    logic [TRIES_W-1:0]  tries;

    modport slave (
        input  start, code, openlock, alarm,
        output out, valid, busy, granted, denied, tries
    );

    modport master (
        output start, code, openlock, alarm,
        input  out, valid, busy, granted, denied, tries
    );
endinterface

// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - serial unlock-code transmitter with response window and retries
//
// Purpose : on start, latches a parallel code and shifts it out MSB first, one bit
//           per clock, then waits RESP_TIMEOUT cycles for openlock/alarm. A silent
//           lock triggers a resend from the latched copy, up to MAX_TRIES attempts.
//           A one-cycle granted/denied pulse reports the outcome.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous active-low reset
//           bus  - lock_code_sender_if.slave (start, code, openlock, alarm in;
//                  out, valid, busy, granted, denied, tries out)
// Options : LOCK_SENDER_PARITY_EN - when defined, an even-parity bit (XOR of the
//           code) follows the code LSB, making each frame CODE_W+1 bits long.
// All outputs are registered.
module lock_code_sender #(
    parameter int CODE_W       = 8,
    parameter int MAX_TRIES    = 3,
    parameter int RESP_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    lock_code_sender_if.slave bus
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
`ifdef LOCK_SENDER_PARITY_EN
    localparam int FRAME   = CODE_W + 1;
`else
    localparam int FRAME   = CODE_W;
`endif
    localparam int BIT_W   = $clog2(FRAME + 1);
    localparam int TMR_W   = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESULT} state_t;

    state_t              state, state_n;

    logic [CODE_W-1:0]   shift_q, shift_n;
    logic [CODE_W-1:0]   code_lat_q, code_lat_n;
    logic [BIT_W-1:0]    bit_q, bit_n;
    logic [TMR_W-1:0]    timer_q, timer_n;
    logic [TRIES_W-1:0]  tries_q, tries_n;
    logic                out_q, out_n;
    logic                valid_q, valid_n;
    logic                busy_q, busy_n;
    logic                granted_q, granted_n;
    logic                denied_q, denied_n;

    // Events decided by the next-state logic and consumed by the datapath.
    logic                load, reload, grant_ev, deny_ev;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        reload   = 1'b0;
        grant_ev = 1'b0;
        deny_ev  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                // Responses are not looked at while the frame is on the wire.
                if (bit_q == BIT_W'(FRAME - 1)) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.alarm) begin
                    state_n = RESULT;
                    deny_ev = 1'b1;
                end else if (bus.openlock) begin
                    state_n  = RESULT;
                    grant_ev = 1'b1;
                end else if (timer_q == TMR_W'(RESP_TIMEOUT - 1)) begin
                    if (tries_q < TRIES_W'(MAX_TRIES)) begin
                        state_n = SEND;
                        reload  = 1'b1;
                    end else begin
                        state_n = RESULT;
                        deny_ev = 1'b1;
                    end
                end
            end
            RESULT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output / datapath next values. Outputs are computed from the next state so
    // that their registered copies line up with the state they describe.
    always_comb begin
        shift_n    = shift_q;
        code_lat_n = code_lat_q;
        bit_n      = bit_q;
        timer_n    = timer_q;
        tries_n    = tries_q;

        if (load) begin
            shift_n    = bus.code;
            code_lat_n = bus.code;
            bit_n      = '0;
            tries_n    = TRIES_W'(1);
        end else if (reload) begin
            // Resend from the latched copy; the live code may have moved on.
            shift_n    = code_lat_q;
            bit_n      = '0;
            tries_n    = tries_q + TRIES_W'(1);
        end else if (state == SEND) begin
            shift_n = shift_q << 1;
            if (state_n == WAIT) begin
                bit_n   = '0;
                timer_n = '0;
            end else begin
                bit_n   = bit_q + BIT_W'(1);
            end
        end else if (state == WAIT) begin
            timer_n = timer_q + TMR_W'(1);
        end

        out_n = 1'b0;
        if (state_n == SEND) begin
            out_n = shift_n[CODE_W-1];
`ifdef LOCK_SENDER_PARITY_EN
            if (bit_n == BIT_W'(CODE_W)) begin
                out_n = ^code_lat_n;
            end
`endif
        end
        valid_n   = (state_n == SEND);
        busy_n    = (state_n != IDLE);
        granted_n = grant_ev;
        denied_n  = deny_ev;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            code_lat_q <= '0;
            bit_q      <= '0;
            timer_q    <= '0;
            tries_q    <= '0;
            out_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            granted_q  <= 1'b0;
            denied_q   <= 1'b0;
        end else begin
            shift_q    <= shift_n;
            code_lat_q <= code_lat_n;
            bit_q      <= bit_n;
            timer_q    <= timer_n;
            tries_q    <= tries_n;
            out_q      <= out_n;
            valid_q    <= valid_n;
            busy_q     <= busy_n;
            granted_q  <= granted_n;
            denied_q   <= denied_n;
        end
    end

    assign bus.out     = out_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.granted = granted_q;
    assign bus.denied  = denied_q;
    assign bus.tries   = tries_q;
endmodule

// File: tb/tb_lock_code_sender.sv
// tb/tb_lock_code_sender.sv - directed self-checking bench for lock_code_sender
module tb_lock_code_sender;
    localparam int CODE_W       = 8;
    localparam int MAX_TRIES    = 3;
    localparam int RESP_TIMEOUT = 4;
`ifdef LOCK_SENDER_PARITY_EN
    localparam int FRAME = CODE_W + 1;
`else
    localparam int FRAME = CODE_W;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    lock_code_sender_if #(.CODE_W(CODE_W), .MAX_TRIES(MAX_TRIES)) bus ();

    lock_code_sender #(
        .CODE_W      (CODE_W),
        .MAX_TRIES   (MAX_TRIES),
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks one full frame; entered at the negedge of the cycle carrying bit 0,
    // leaves at the negedge of the first cycle after the frame.
    task automatic check_frame(input logic [CODE_W-1:0] exp_code, input string tag);
        logic [CODE_W-1:0] c;
        c = exp_code;
        for (int i = 0; i < FRAME; i++) begin
            if (i < CODE_W) check($sformatf("%s_bit%0d", tag, i), bus.out, c[CODE_W-1-i]);
            else            check($sformatf("%s_par", tag), bus.out, ^c);
            check($sformatf("%s_valid%0d", tag, i), bus.valid, 1'b1);
            step();
        end
    endtask

    // Pulses start for one edge; returns at the negedge of bit 0.
    task automatic kick(input logic [CODE_W-1:0] c);
        bus.code  = c;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst          = 1'b0;
        bus.start    = 1'b1;
        bus.code     = 8'hFF;
        bus.openlock = 1'b0;
        bus.alarm    = 1'b0;

        // Reset hold with start asserted
        step();
        step();
        check("rst_out",     bus.out,     1'b0);
        check("rst_valid",   bus.valid,   1'b0);
        check("rst_busy",    bus.busy,    1'b0);
        check("rst_granted", bus.granted, 1'b0);
        check("rst_denied",  bus.denied,  1'b0);
        check("rst_tries",   bus.tries,   2'd0);
        bus.start = 1'b0;
        rst       = 1'b1;
        step();
        check("idle_busy", bus.busy, 1'b0);

        // Grant path, openlock in the 2nd window cycle
        kick(8'b1011_0010);
        check("g_busy", bus.busy, 1'b1);
        check("g_tries", bus.tries, 2'd1);
        check_frame(8'b1011_0010, "g");
        check("g_win_valid", bus.valid, 1'b0);
        check("g_win_out",   bus.out,   1'b0);
        step();
        bus.openlock = 1'b1;
        step();
        bus.openlock = 1'b0;
        check("g_granted", bus.granted, 1'b1);
        check("g_denied",  bus.denied,  1'b0);
        check("g_res_busy", bus.busy, 1'b1);
        step();
        check("g_granted_end", bus.granted, 1'b0);
        check("g_idle_busy", bus.busy, 1'b0);
        check("g_tries_hold", bus.tries, 2'd1);

        // Alarm wins over openlock
        kick(8'h5A);
        check_frame(8'h5A, "a");
        bus.openlock = 1'b1;
        bus.alarm    = 1'b1;
        step();
        bus.openlock = 1'b0;
        bus.alarm    = 1'b0;
        check("a_denied",  bus.denied,  1'b1);
        check("a_granted", bus.granted, 1'b0);
        step();
        check("a_idle_busy", bus.busy, 1'b0);

        // Silent lock: three frames from the latched code, then denied
        kick(8'hC3);
        bus.code = 8'h3C;
        for (int t = 1; t <= MAX_TRIES; t++) begin
            check($sformatf("r_tries%0d", t), bus.tries, t);
            check_frame(8'hC3, $sformatf("r%0d", t));
            for (int w = 0; w < RESP_TIMEOUT; w++) begin
                check($sformatf("r%0d_win%0d_valid", t, w), bus.valid, 1'b0);
                check($sformatf("r%0d_win%0d_denied", t, w), bus.denied, 1'b0);
                step();
            end
        end
        check("r_denied", bus.denied, 1'b1);
        check("r_granted", bus.granted, 1'b0);
        check("r_tries_final", bus.tries, 2'd3);
        step();
        check("r_idle_busy", bus.busy, 1'b0);
        check("r_tries_hold", bus.tries, 2'd3);

        // Start re-pulsed during SEND, then reset at bit 4
        kick(8'hE1);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = 8'hE1;
            check($sformatf("s_bit%0d", i), bus.out, e[7-i]);
            bus.start = (i == 1);
            if (i == 1) bus.code = 8'h00;
            step();
        end
        bus.start = 1'b0;
        check("s_tries", bus.tries, 2'd1);
        #1 rst = 1'b0;
        #1;
        check("s_rst_out",   bus.out,   1'b0);
        check("s_rst_valid", bus.valid, 1'b0);
        check("s_rst_busy",  bus.busy,  1'b0);
        check("s_rst_tries", bus.tries, 2'd0);
        step();
        rst = 1'b1;
        step();
        kick(8'h96);
        check_frame(8'h96, "s2");
        bus.openlock = 1'b1;
        step();
        bus.openlock = 1'b0;
        check("s2_granted", bus.granted, 1'b1);
        step();

`ifdef LOCK_SENDER_PARITY_EN
        // Parity frame: 0x07 carries an odd number of ones, so the 9th bit is 1
        kick(8'h07);
        check_frame(8'h07, "p");
        check("p_after_valid", bus.valid, 1'b0);
        bus.alarm = 1'b1;
        step();
        bus.alarm = 1'b0;
        check("p_denied", bus.denied, 1'b1);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lock_code_sender.md
# lock_code_sender

Serial code transmitter that drives the input of the Moore serial lock. On a start request it latches a parallel unlock code and shifts it out one bit per clock, MSB first, then waits a bounded window for the lock's `openlock`/`alarm` response. It retries on a silent lock and reports a final granted/denied result. It sits between the keypad/controller logic and the lock FSM.

## Interface
- `CODE_W`, 8: code length in bits (≥2).
- `MAX_TRIES`, 3: total transmission attempts per start (≥1).
- `RESP_TIMEOUT`, 4: response window length in cycles (≥1).
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `code`  in  CODE_W  unlock code; latched on an accepted `start`.
- `openlock`  in  1  lock response: code accepted.
- `alarm`  in  1  lock response: code rejected.
- `out`  out  1  serial bit to the lock `in`.
- `valid`  out  1  high while `out` carries a code bit.
- `busy`  out  1  high in every state except IDLE.
- `granted`  out  1  one-cycle pulse: the lock opened.
- `denied`  out  1  one-cycle pulse: alarm, or all tries exhausted.
- `tries`  out  $clog2(MAX_TRIES+1)  attempts started for the current request.

## Operation
- States: IDLE, SEND, WAIT, RESULT.
- IDLE: `out`=0, `valid`=0, `busy`=0. When `start`=1, load shift register from `code`, set bit counter to 0 and `tries` to 1, then go to SEND.
- SEND: `out`=shift[MSB], `valid`=1. Shift left by one each cycle. After the last bit, go to WAIT with the timer cleared.
- WAIT: `out`=0, `valid`=0. Sample the responses each cycle.
  - `alarm` takes priority when both responses are high: go to RESULT with `denied`.
  - `openlock` alone: go to RESULT with `granted`.
  - Timer reaches RESP_TIMEOUT−1 with no response:
    - If `tries` < MAX_TRIES: increment `tries`, reload the shift register from the latched copy (not the live `code`), and go to SEND.
    - Otherwise go to RESULT with `denied`.
- RESULT: exactly one of `granted`/`denied` is high for one cycle. `busy` stays 1. Next state is IDLE.
- `start` is ignored in every state except IDLE. `code` changes after acceptance have no effect.
- Responses arriving during SEND are ignored.
- `tries` holds its final value in IDLE until the next accepted `start`.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `out`, `valid`, `busy`, `granted`, `denied` = 0; `tries`=0; shift register, counters and timer = 0.
- All outputs are registered.
- Accepted `start` at edge k:
  - bit i appears on `out` in cycle k+1+i, for i = 0..CODE_W−1;
  - `valid` is high for cycles k+1..k+CODE_W;
  - `busy` rises in cycle k+1.
- The response window covers cycles k+CODE_W+1 .. k+CODE_W+RESP_TIMEOUT.
- A response sampled at edge j gives a `granted`/`denied` pulse in cycle j+1 and IDLE in cycle j+2.
- A retry's first bit appears the cycle after the timeout edge. There is no idle gap.
- Reset asserted mid-SEND: `out` and `valid` drop immediately, and the transfer is abandoned.

## Configuration
- `LOCK_SENDER_PARITY_EN` defined:
  - one even-parity bit (XOR of the code) is sent after the code LSB, with `valid`=1;
  - a frame is CODE_W+1 cycles, and the response window starts one cycle later.
- Undefined: frames are exactly CODE_W bits, with no parity logic.

## Test plan
- Reset hold: `rst`=0 for 2 cycles with `start`=1 → all outputs 0, `tries`=0, state stays IDLE.
- Grant path: `code`=8'b1011_0010, `start` pulse, `openlock`=1 in the 2nd window cycle → `out` serial 1,0,1,1,0,0,1,0 with `valid`=1 for 8 cycles; `granted` pulse; `tries`=1.
- Alarm priority: `openlock`=1 and `alarm`=1 together in the window → `denied` pulse only, no `granted`.
- Retry/timeout: lock silent → three identical 8-bit frames with no gap; `tries` steps 1,2,3; `denied` after the 3rd window; `code` changed mid-transfer is not reflected in later frames.
- Start while busy plus reset mid-SEND: `start` re-pulsed during SEND → ignored; `rst`=0 at bit 4 → `out`, `valid`, `busy` drop the same cycle, and the next `start` restarts at bit 0.
- Parity (with macro): `code`=8'h07 → 9 bits sent, the 9th bit is 1.
